// File: rtl/alu_packet_engine_if.sv
// Byte-stream bus of the ALU packet engine: UART receive side in,
// UART transmit side out, plus the reject pulse.
// master = the surrounding system, slave = the engine.
interface alu_packet_engine_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       err_o;

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, err_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, err_o
    );
endinterface

// File: rtl/alu_packet_engine.sv
// ALU packet engine: parses opcode/reserved/length-LSB/length-MSB headers
// from a UART byte stream and then either echoes the payload, or folds
// the payload's 32-bit little-endian operands with add (or multiply) and
// returns the 32-bit result LSB first. Bad packets pulse err_o.
// Optional feature macro: ALU_MUL_EN -- when defined, opcode 0xA7
// multiplies; when undefined, 0xA7 is an unknown opcode and no multiplier
// is built.
module alu_packet_engine #(
    parameter int LEN_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_packet_engine_if.slave  bus
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
`ifdef ALU_MUL_EN
    localparam logic [7:0] OP_MUL  = 8'hA7;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_RSV, S_LEN_L, S_LEN_H, S_ECHO, S_OPND, S_RESULT, S_DRAIN
    } state_t;

    state_t           state_q;
    logic [7:0]       op_q;
    logic [7:0]       len_lo_q;
    logic [LEN_W-1:0] cnt_q;        // payload bytes still to be received
    logic [23:0]      opnd_q;       // first three bytes of the operand in flight
    logic             first_q;      // next completed operand loads the accumulator
`ifdef ALU_MUL_EN
    logic             is_mul_q;
`endif
    logic [31:0]      acc_q;
    logic [1:0]       res_idx_q;    // index of the result byte on tx_data_o
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             err_q;

    logic [15:0]      len_raw_s;
    logic [LEN_W-1:0] len_s;
    logic [LEN_W-1:0] pay_s;
    logic [31:0]      operand_s;
    logic [31:0]      acc_next_s;
    logic             is_alu_op_s;
    logic [7:0]       acc_byte_s;
    logic             rx_ready_s;
    logic             rx_fire_s;

    // Header length decode and accumulator next value for the completing operand.
    always_comb begin
        len_raw_s = {bus.rx_data_i, len_lo_q};
        len_s     = LEN_W'(len_raw_s);
        pay_s     = len_s - LEN_W'(4);
        operand_s = {bus.rx_data_i, opnd_q};
`ifdef ALU_MUL_EN
        is_alu_op_s = (op_q == OP_ADD) || (op_q == OP_MUL);
        if (first_q) begin
            acc_next_s = operand_s;
        end else if (is_mul_q) begin
            acc_next_s = acc_q * operand_s;
        end else begin
            acc_next_s = acc_q + operand_s;
        end
`else
        is_alu_op_s = (op_q == OP_ADD);
        if (first_q) begin
            acc_next_s = operand_s;
        end else begin
            acc_next_s = acc_q + operand_s;
        end
`endif
    end

    // Select the accumulator byte that follows the one currently presented.
    always_comb begin
        acc_byte_s = acc_q[7:0];
        case (res_idx_q)
            2'd0:    acc_byte_s = acc_q[15:8];
            2'd1:    acc_byte_s = acc_q[23:16];
            2'd2:    acc_byte_s = acc_q[31:24];
            default: acc_byte_s = acc_q[7:0];
        endcase
    end

    // Receive readiness; in ECHO the single buffer may refill in the cycle it drains.
    always_comb begin
        rx_ready_s = 1'b0;
        if (rst_i) begin
            rx_ready_s = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_RSV, S_LEN_L, S_LEN_H: rx_ready_s = 1'b1;
                S_ECHO:   rx_ready_s = (cnt_q != '0) && (!tx_valid_q || bus.tx_ready_i);
                S_OPND:   rx_ready_s = 1'b1;
                S_RESULT: rx_ready_s = 1'b0;
                S_DRAIN:  rx_ready_s = (cnt_q != '0);
                default:  rx_ready_s = 1'b0;
            endcase
        end
    end

    assign rx_fire_s      = bus.rx_valid_i && rx_ready_s;
    assign bus.rx_ready_o = rx_ready_s;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.err_o      = err_q;

    // Packet FSM with registered transmit byte, valid and reject pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= 8'h00;
            len_lo_q   <= 8'h00;
            cnt_q      <= '0;
            opnd_q     <= 24'h000000;
            first_q    <= 1'b1;
`ifdef ALU_MUL_EN
            is_mul_q   <= 1'b0;
`endif
            acc_q      <= 32'h0000_0000;
            res_idx_q  <= 2'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_fire_s) begin
                        op_q    <= bus.rx_data_i;
                        state_q <= S_RSV;
                    end
                end
                S_RSV: begin
                    if (rx_fire_s) begin
                        state_q <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (rx_fire_s) begin
                        len_lo_q <= bus.rx_data_i;
                        state_q  <= S_LEN_H;
                    end
                end
                S_LEN_H: begin
                    if (rx_fire_s) begin
                        cnt_q   <= pay_s;
                        first_q <= 1'b1;
`ifdef ALU_MUL_EN
                        is_mul_q <= (op_q == OP_MUL);
`endif
                        if (len_s < LEN_W'(4)) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (op_q == OP_ECHO) begin
                            state_q <= (pay_s == '0) ? S_IDLE : S_ECHO;
                        end else if (is_alu_op_s) begin
                            if ((pay_s == '0) || (pay_s[1:0] != 2'b00)) begin
                                err_q   <= 1'b1;
                                state_q <= S_DRAIN;
                            end else begin
                                state_q <= S_OPND;
                            end
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_ECHO: begin
                    if (rx_fire_s) begin
                        tx_data_q  <= bus.rx_data_i;
                        tx_valid_q <= 1'b1;
                        cnt_q      <= cnt_q - LEN_W'(1);
                    end else if (!tx_valid_q || bus.tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_OPND: begin
                    if (rx_fire_s) begin
                        opnd_q <= {bus.rx_data_i, opnd_q[23:8]};
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (cnt_q[1:0] == 2'b01) begin
                            acc_q   <= acc_next_s;
                            first_q <= 1'b0;
                            if (cnt_q == LEN_W'(1)) begin
                                tx_data_q  <= acc_next_s[7:0];
                                tx_valid_q <= 1'b1;
                                res_idx_q  <= 2'd0;
                                state_q    <= S_RESULT;
                            end
                        end
                    end
                end
                S_RESULT: begin
                    if (bus.tx_ready_i) begin
                        if (res_idx_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            tx_data_q <= acc_byte_s;
                            res_idx_q <= res_idx_q + 2'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else if (rx_fire_s) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Self-checking bench for alu_packet_engine: directed vectors with literal
// expectations, then randomized packets checked against a packet-level model.
module tb_alu_packet_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_packet_engine_if bus();

    alu_packet_engine #(.LEN_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int err_seen = 0;
    int exp_err;
    int tx_mode = 0;          // 0: ready always, 1: random, 2: held low
    bit mul_en;

    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    logic [7:0] mdl_tx_q[$];
    logic [7:0] lit_q[$];
    int         mdl_err;
    int         lit_err;

    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic       prev_rst = 1'b1;
    logic [7:0] prev_d = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, req);
    endtask

    // Packet-level reference: what the transmitter must see and whether it is rejected.
    task automatic run_model();
        logic [7:0]  op;
        int          len;
        int          pay;
        logic [31:0] acc;
        logic [31:0] v;
        mdl_tx_q.delete();
        mdl_err = 0;
        acc = 32'h0;
        op  = pkt_q[0];
        len = int'({pkt_q[3], pkt_q[2]});
        if (len < 4) begin
            mdl_err = 1;
            return;
        end
        pay = len - 4;
        if (op == 8'hEC) begin
            for (int i = 0; i < pay; i++) mdl_tx_q.push_back(pkt_q[4+i]);
        end else if (op == 8'hAD || (op == 8'hA7 && mul_en)) begin
            if (pay == 0 || pay % 4 != 0) begin
                mdl_err = 1;
            end else begin
                for (int k = 0; k < pay / 4; k++) begin
                    v = {pkt_q[7+4*k], pkt_q[6+4*k], pkt_q[5+4*k], pkt_q[4+4*k]};
                    if (k == 0)          acc = v;
                    else if (op == 8'hAD) acc = acc + v;
                    else                 acc = acc * v;
                end
                for (int b = 0; b < 4; b++) mdl_tx_q.push_back(8'((acc >> (8*b)) & 32'hFF));
            end
        end else begin
            mdl_err = 1;
        end
    endtask

    // Transmit-ready driver, updated just after each rising edge.
    initial begin
        bus.tx_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                0:       bus.tx_ready_i = 1'b1;
                1:       bus.tx_ready_i = ($urandom_range(0, 3) != 0);
                default: bus.tx_ready_i = 1'b0;
            endcase
        end
    end

    // Compare process: every transmitted byte, the hold rule, and reject pulses.
    always @(negedge clk) begin
        if (!rst && !prev_rst && prev_v && !prev_r) begin
            chk("tx_hold_valid", bus.tx_valid_o, 1'b1);
            chk("tx_hold_data", bus.tx_data_o, prev_d);
        end
        if (!rst) begin
            if (bus.err_o) err_seen++;
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                if (exp_q.size() == 0) chk("tx_unexpected", bus.tx_valid_o, 1'b0);
                else                   chk("tx_byte", bus.tx_data_o, exp_q.pop_front());
            end
        end
        prev_v   <= bus.tx_valid_o;
        prev_r   <= bus.tx_ready_i;
        prev_d   <= bus.tx_data_o;
        prev_rst <= rst;
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n = 0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept", bus.rx_ready_o, 1'b1);
        @(posedge clk);
        #1;
        bus.rx_valid_i = 1'b0;
        for (int g = 0; g < $urandom_range(0, max_gap); g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int max_gap);
        foreach (pkt_q[i]) send_byte(pkt_q[i], max_gap);
    endtask

    task automatic wait_done(input string nm, input int err_base);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_tx_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk({nm, "_err"}, err_seen - err_base, exp_err);
        chk({nm, "_idle_ready"}, bus.rx_ready_o, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tx_valid", bus.tx_valid_o, 1'b0);
        chk("rst_tx_data", bus.tx_data_o, 8'h00);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_rx_ready", bus.rx_ready_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("ready_after_reset", bus.rx_ready_o, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Pin the model against literal expectations, then run the packet through the DUT.
    task automatic run_directed(input string nm);
        int base;
        run_model();
        chk({nm, "_model_len"}, mdl_tx_q.size(), lit_q.size());
        chk({nm, "_model_err"}, mdl_err, lit_err);
        foreach (lit_q[i]) if (i < mdl_tx_q.size()) chk({nm, "_model_byte"}, mdl_tx_q[i], lit_q[i]);
        foreach (lit_q[i]) exp_q.push_back(lit_q[i]);
        exp_err = lit_err;
        base = err_seen;
        send_pkt(0);
        wait_done(nm, base);
    endtask

    task automatic gen_random_pkt();
        int kind;
        int pay;
        int len;
        logic [7:0] op;
        pkt_q.delete();
        kind = $urandom_range(0, 5);
        pay  = 0;
        op   = 8'hEC;
        case (kind)
            0: begin op = 8'hEC; pay = $urandom_range(0, 6); end
            1: begin op = 8'hAD; pay = 4 * $urandom_range(1, 3); end
            2: begin op = 8'hA7; pay = 4 * $urandom_range(1, 3); end
            3: begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'hEC || op == 8'hAD || op == 8'hA7) op = 8'($urandom_range(0, 255));
                pay = $urandom_range(0, 5);
            end
            4: begin
                op  = ($urandom_range(0, 1) == 0) ? 8'hAD : 8'hA7;
                pay = $urandom_range(0, 7);
                if (pay == 4) pay = 0;
            end
            default: begin op = 8'hAD; pay = 0; end
        endcase
        len = (kind == 5) ? $urandom_range(0, 3) : pay + 4;
        pkt_q.push_back(op);
        pkt_q.push_back(8'($urandom_range(0, 255)));
        pkt_q.push_back(8'(len & 255));
        pkt_q.push_back(8'(len >> 8));
        for (int i = 0; i < pay; i++)
            pkt_q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int base;
        int n;
`ifdef ALU_MUL_EN
        mul_en = 1'b1;
`else
        mul_en = 1'b0;
`endif
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        lit_q = '{8'h41, 8'h42, 8'h43};
        lit_err = 0;
        run_directed("echo");

        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        lit_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        lit_err = 0;
        run_directed("add_wrap");

        pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        lit_q.delete();
        lit_err = 1;
        run_directed("bad_opcode");

        pkt_q = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02};
        lit_q.delete();
        lit_err = 1;
        run_directed("bad_add_len");

        pkt_q = '{8'hA7, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
`ifdef ALU_MUL_EN
        lit_q = '{8'h15, 8'h00, 8'h00, 8'h00};
        lit_err = 0;
`else
        lit_q.delete();
        lit_err = 1;
`endif
        run_directed("mul");

        pkt_q = '{8'hEC, 8'h00, 8'h02, 8'h00};
        lit_q.delete();
        lit_err = 1;
        run_directed("short_len");

        // Backpressure: result held on the bus while the transmitter stalls.
        tx_mode = 2;
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        exp_q = '{8'h08, 8'h00, 8'h00, 8'h00};
        exp_err = 0;
        base = err_seen;
        send_pkt(0);
        n = 0;
        @(negedge clk);
        while (!bus.tx_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.tx_valid_o, 1'b1);
            chk("bp_data", bus.tx_data_o, 8'h08);
            chk("bp_rx_ready", bus.rx_ready_o, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        tx_mode = 0;
        wait_done("backpressure", base);

        // Reset in the middle of an add packet abandons it.
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
        send_pkt(0);
        do_reset();
        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        lit_q = '{8'h5A};
        lit_err = 0;
        run_directed("after_reset");

        // Randomized packets against the model, with transmitter stalls and input gaps.
        tx_mode = 1;
        for (int p = 0; p < 40; p++) begin
            gen_random_pkt();
            run_model();
            foreach (mdl_tx_q[i]) exp_q.push_back(mdl_tx_q[i]);
            exp_err = mdl_err;
            base = err_seen;
            send_pkt(2);
            wait_done("random", base);
        end
        tx_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
